decode_queue: RTL
=================

Name: decode_queue

Overview:
- Parametrised successor to the combinational control unit. It decodes each fetched instruction, then buffers the decoded control bundle in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- Decouples fetch from execute.
- Adds optional M-extension legality checking.
- Serialises SYSTEM/FENCE.I instructions: fetch is blocked until the backend reports completion.

Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- XLEN, 32: PC width.
- MEXT_EN, 0: 1 makes REGREG with funct7=7'b0000001 legal.
- LOOP_HALT_EN, 1: 1 flags instr 32'h0000006f as halt.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- flush  in  1  discard all queued entries
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  queue accepts
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  instruction PC
- out_valid  out  1  head entry valid
- out_ready  in  1  execute consumes head
- out_pc  out  XLEN  head PC
- out_opcode  out  7  head opcode (0 if unknown)
- out_rs1, out_rs2, out_rd  out  5 each  register indices (0 if unknown opcode)
- out_imm  out  32  selected, sign-extended immediate
- out_alu_op  out  4  alu_op_t
- out_wen, out_dren, out_dwen, out_branch, out_jump  out  1 each  control flags
- out_illegal  out  1  illegal instruction
- out_halt  out  1  halt flag
- out_serialize  out  1  head is SYSTEM or FENCE.I
- serialize_done  in  1  backend pulse: serialising instr completed
- count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset: FIFO pointers and count are 0; state is RUN. Outputs: out_valid=0, in_ready=1, count=0. Payload outputs are 0 (head storage cleared).
- Push: occurs when in_valid && in_ready. Decode is combinational on in_instr and is written into the tail entry the same edge.
- Pop: occurs when out_valid && out_ready. Payload outputs are registered head contents.
- Latency: an instruction pushed at edge N is visible with out_valid=1 after edge N; no combinational bypass.
- in_ready = (count < DEPTH) && state==RUN. Push and pop in the same cycle leave count unchanged.
- Pointers wrap modulo DEPTH. Pop when empty and push when full are impossible by construction.
- Immediate selection:
  - I: IMMED, LOAD, JALR, SYSTEM
  - S: STORE
  - SB: BRANCH
  - U: LUI, AUIPC
  - UJ: JAL
  - all others: 0
  - All immediates are sign-extended to 32 bits; SB and UJ have bit 0 = 0.
- ALU op:
  - Same mapping as the existing control unit: shifts use instr[30]; ADD for LOAD/STORE/AUIPC/default.
- Illegal:
  - opcode not in the RV32I set, or
  - REGREG with funct7 not in {0x00, 0x20}, or funct7=0x01 when MEXT_EN=1.
  - Illegal entries are still queued.
- Serialisation FSM:
  - RUN -> DRAIN: on push of a serialising instr (SYSTEM, or MISCMEM with funct3=001).
  - DRAIN -> WAIT: when that entry pops. Only one serialising entry can exist, because in_ready is low in DRAIN.
  - WAIT -> RUN: on serialize_done.
  - serialize_done outside WAIT is ignored.
- Flush:
  - Takes priority over push and pop in the same cycle.
  - Clears pointers and count; state returns to RUN.
  - After the edge, out_valid=0 and in_ready=1. A concurrent in_valid instruction is dropped.
- RST mid-operation behaves like flush plus clears payload registers; it is asynchronous.

Decomposition:
- decode_queue_pkg holds:
  - decoded_t packed struct (pc, opcode, rs1/rs2/rd, imm, alu_op, flags, illegal, halt, serialize)
  - dq_state_t {RUN, DRAIN, WAIT}
  - FUNCT7_MULDIV constant
- alu_op_t encodings are reused from alu_types_pkg; opcode_t from rv32i_types_pkg.
- Sub-module decode_logic: purely combinational in_instr/in_pc -> decoded_t, parametrised by MEXT_EN and LOOP_HALT_EN.
- The top level holds the FIFO array and FSM.

Test Plan:
- Reset, then push 0x00500093 with pc 0x200 -> one edge later: out_valid=1, out_pc=0x200, rd=1, rs1=0, imm=5, alu_op=ALU_ADD, wen=1, count=1.
- out_ready=0, push 4 ADDIs (DEPTH=4) -> count=4, in_ready=0, 5th held. Assert out_ready one cycle -> count=3, in_ready=1. Next push+pop simultaneous -> count stays 3.
- Push 0x30029073 (CSRRW mstatus) then offer ADDI -> in_ready=0 after CSRRW. Pop CSRRW: out_serialize=1, imm=0x300. ADDI is not accepted until serialize_done pulses; accepted the cycle after.
- Push 0x02208033 -> out_illegal=1 when MEXT_EN=0; out_illegal=0 when MEXT_EN=1.
- 3 entries queued, flush with in_valid=1 -> next cycle count=0, out_valid=0, offered instr absent. The queue is usable on the following push.
- Push 0xFE000EE3 (beq -4) -> out_branch=1, imm=0xFFFFFFFC. Push 0x0000006f -> out_halt=1, out_jump=1, imm=0.

Source files
------------

// File: rtl/alu_types_pkg.sv
// ALU operation encodings consumed by the execute stage.
package alu_types_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

endpackage

// File: rtl/decode_queue_pkg.sv
// Shared types for the decode queue: decoded control bundle and FSM states.
package decode_queue_pkg;
  import alu_types_pkg::*;

  // Widest PC the bundle can carry; narrower XLEN values are zero-extended.
  localparam int unsigned PC_MAX_W = 64;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    WAIT  = 2'd2
  } dq_state_t;

  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    logic [6:0]          opcode;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic [31:0]         imm;
    alu_op_t             alu_op;
    logic                wen;
    logic                dren;
    logic                dwen;
    logic                branch;
    logic                jump;
    logic                illegal;
    logic                halt;
    logic                serialize;
  } decoded_t;

endpackage

// File: rtl/rv32i_types_pkg.sv
// RV32I base opcode encodings shared across the decode path.
package rv32i_types_pkg;

  typedef enum logic [6:0] {
    OP_LUI     = 7'b0110111,
    OP_AUIPC   = 7'b0010111,
    OP_JAL     = 7'b1101111,
    OP_JALR    = 7'b1100111,
    OP_BRANCH  = 7'b1100011,
    OP_LOAD    = 7'b0000011,
    OP_STORE   = 7'b0100011,
    OP_IMMED   = 7'b0010011,
    OP_REGREG  = 7'b0110011,
    OP_MISCMEM = 7'b0001111,
    OP_SYSTEM  = 7'b1110011
  } opcode_t;

endpackage

// File: rtl/decode_queue_decode_logic.sv
// Combinational RV32I decoder: raw instruction + PC -> decoded control bundle.
module decode_logic
  import decode_queue_pkg::*;
  import alu_types_pkg::*;
  import rv32i_types_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int MEXT_EN      = 0,
  parameter int LOOP_HALT_EN = 1
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output decoded_t        dec
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  alu_op_t     arith_op;
  logic        funct7_ok;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign funct7_ok = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT) ||
                     ((MEXT_EN != 0) && (funct7 == FUNCT7_MULDIV));

  // Arithmetic op for REGREG/IMMED; instr[30] selects SUB (REGREG only) and SRA.
  always_comb begin
    arith_op = ALU_ADD;
    unique case (funct3)
      3'b000: arith_op = ((opcode == OP_REGREG) && instr[30]) ? ALU_SUB : ALU_ADD;
      3'b001: arith_op = ALU_SLL;
      3'b010: arith_op = ALU_SLT;
      3'b011: arith_op = ALU_SLTU;
      3'b100: arith_op = ALU_XOR;
      3'b101: arith_op = instr[30] ? ALU_SRA : ALU_SRL;
      3'b110: arith_op = ALU_OR;
      3'b111: arith_op = ALU_AND;
      default: arith_op = ALU_ADD;
    endcase
  end

  // Per-opcode control bundle; unknown opcodes leave everything zero but illegal.
  always_comb begin
    dec        = '0;
    dec.pc     = PC_MAX_W'(pc);
    dec.alu_op = ALU_ADD;
    dec.halt   = (LOOP_HALT_EN != 0) && (instr == 32'h0000006f);
    dec.opcode = opcode;
    dec.rs1    = instr[19:15];
    dec.rs2    = instr[24:20];
    dec.rd     = instr[11:7];
    case (opcode)
      OP_LUI: begin
        dec.imm    = imm_u;
        dec.alu_op = ALU_PASSB;
        dec.wen    = 1'b1;
      end
      OP_AUIPC: begin
        dec.imm = imm_u;
        dec.wen = 1'b1;
      end
      OP_JAL: begin
        dec.imm  = imm_j;
        dec.wen  = 1'b1;
        dec.jump = 1'b1;
      end
      OP_JALR: begin
        dec.imm  = imm_i;
        dec.wen  = 1'b1;
        dec.jump = 1'b1;
      end
      OP_BRANCH: begin
        dec.imm    = imm_b;
        dec.alu_op = ALU_SUB;
        dec.branch = 1'b1;
      end
      OP_LOAD: begin
        dec.imm  = imm_i;
        dec.wen  = 1'b1;
        dec.dren = 1'b1;
      end
      OP_STORE: begin
        dec.imm  = imm_s;
        dec.dwen = 1'b1;
      end
      OP_IMMED: begin
        dec.imm    = imm_i;
        dec.alu_op = arith_op;
        dec.wen    = 1'b1;
      end
      OP_REGREG: begin
        dec.alu_op  = arith_op;
        dec.wen     = 1'b1;
        dec.illegal = !funct7_ok;
      end
      OP_MISCMEM: begin
        dec.serialize = (funct3 == 3'b001);
      end
      OP_SYSTEM: begin
        dec.imm       = imm_i;
        dec.wen       = (funct3 != 3'b000);
        dec.serialize = 1'b1;
      end
      default: begin
        dec.opcode  = '0;
        dec.rs1     = '0;
        dec.rs2     = '0;
        dec.rd      = '0;
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// Decode queue: decodes fetched instructions into a DEPTH-entry FIFO and
// blocks fetch around serialising instructions until the backend completes them.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int XLEN         = 32,
  parameter int MEXT_EN      = 0,
  parameter int LOOP_HALT_EN = 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [XLEN-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [6:0]                 out_opcode,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [4:0]                 out_rd,
  output logic [31:0]                out_imm,
  output logic [3:0]                 out_alu_op,
  output logic                       out_wen,
  output logic                       out_dren,
  output logic                       out_dwen,
  output logic                       out_branch,
  output logic                       out_jump,
  output logic                       out_illegal,
  output logic                       out_halt,
  output logic                       out_serialize,
  input  logic                       serialize_done,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  decoded_t         mem [DEPTH];
  decoded_t         dec_in;
  decoded_t         head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  dq_state_t        state;
  logic             push;
  logic             pop;
  logic             unused_pc_hi;

  decode_logic #(
    .XLEN         (XLEN),
    .MEXT_EN      (MEXT_EN),
    .LOOP_HALT_EN (LOOP_HALT_EN)
  ) u_decode (
    .instr (in_instr),
    .pc    (in_pc),
    .dec   (dec_in)
  );

  assign in_ready  = (count < CNT_W'(DEPTH)) && (state == RUN);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign head      = mem[rd_ptr];

  // Write the decoded bundle into the tail entry; reset clears all storage.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= dec_in;
    end
  end

  // Pointers and occupancy; flush empties the queue without touching storage.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Serialisation FSM: block fetch from push of a serialising entry until
  // it has left the queue and the backend reports completion.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= RUN;
    end else if (flush) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     if (push && dec_in.serialize) state <= DRAIN;
        DRAIN:   if (pop && head.serialize)    state <= WAIT;
        WAIT:    if (serialize_done)           state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  assign out_pc        = head.pc[XLEN-1:0];
  assign out_opcode    = head.opcode;
  assign out_rs1       = head.rs1;
  assign out_rs2       = head.rs2;
  assign out_rd        = head.rd;
  assign out_imm       = head.imm;
  assign out_alu_op    = head.alu_op;
  assign out_wen       = head.wen;
  assign out_dren      = head.dren;
  assign out_dwen      = head.dwen;
  assign out_branch    = head.branch;
  assign out_jump      = head.jump;
  assign out_illegal   = head.illegal;
  assign out_halt      = head.halt;
  assign out_serialize = head.serialize;

  // PC bits above XLEN are always zero in storage.
  assign unused_pc_hi  = ^head.pc;

endmodule
